des_block_engine: RTL
=====================

# des_block_engine

Iterative DES block cipher engine. Holds the 64-bit data block and 56-bit key state in registers and applies a parametrised number of Feistel rounds per clock. Each round uses the existing `Eff` f-function: 32-bit half plus 48-bit subkey in, 32-bit result out. Sits between a request/response stream producer and consumer, and supports both encryption and decryption.

## Interface
Parameters:
- `ROUNDS_PER_CYCLE`, default 1: Feistel rounds per clock.
  - Legal values are 1, 2, 4, 8 and 16.
  - Any other value raises `$error` at elaboration.

Ports:
- `clk`, in, 1: clock. All state changes on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `in_valid`, in, 1: request present.
- `in_ready`, out, 1: engine can accept a request. Equals state==IDLE.
- `in_decrypt`, in, 1: 0 = encrypt, 1 = decrypt. Sampled on accept.
- `in_data`, in, 64: plaintext or ciphertext. DES bit 1 is `[63]`.
- `in_key`, in, 64: key including parity bits (8,16,…,64). DES bit 1 is `[63]`.
- `out_valid`, out, 1: result present. Equals state==DONE.
- `out_ready`, in, 1: consumer accepts the result.
- `out_data`, out, 64: result block, held stable while `out_valid` is high.
- `out_err`, out, 1: key parity error for this result (see Configuration). Valid when `out_valid` is high.
- `busy`, out, 1: state != IDLE.

## Operation
State machine: IDLE, RUN, DONE.

IDLE:
- Accept occurs when `in_valid && in_ready`. On accept:
  - L‖R ← IP(`in_data`).
  - C‖D ← PC1(`in_key`).
  - mode ← `in_decrypt`.
  - round counter ← 0.
  - Next state is RUN.
- With no accept, stay in IDLE.

RUN, each cycle performs `ROUNDS_PER_CYCLE` chained rounds, combinationally. For round i (0..15):
- Encrypt: rotate C and D left by SHIFT[i], where SHIFT = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- Decrypt: rotate C and D right by RSHIFT[i], where RSHIFT = 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- K ← PC2(C‖D).
- L' ← R.
- R' ← L ^ Eff(R, K).
- The counter advances by `ROUNDS_PER_CYCLE`.
- When the counter reaches 16, `out_data` ← FP(R‖L), i.e. halves swapped, and the next state is DONE.

DONE:
- `out_valid` = 1.
- On `out_ready`, go to IDLE.
- `in_ready` is 0 while in DONE. A request arriving in the same cycle as `out_ready` is accepted no earlier than the next cycle.

Boundary behaviour:
- While in RUN or DONE, `in_*` inputs are ignored, with no buffering.
- Asserting `rst` in any state immediately forces IDLE. The in-flight block is discarded and no `out_valid` is produced for it.
- `out_data` and `out_err` hold their last values in IDLE. Consumers must not rely on them there.

Reset values:
- state IDLE.
- `in_ready` = 1.
- `out_valid` = 0.
- `busy` = 0.
- `out_data` = 0.
- `out_err` = 0.
- Internal L, R, C, D and counter are all 0.

## Timing
- Let N = 16 / `ROUNDS_PER_CYCLE`. If the accept is at rising edge 0, `out_valid` rises after edge N.
  - N=16 for R=1, N=1 for R=16.
- Throughput is one block per N+2 cycles when `out_ready` is held at 1: accept, N RUN cycles, one DONE cycle.
- The f-function critical path scales with `ROUNDS_PER_CYCLE`: R chained `Eff` instances plus the key rotate and PC2 logic.
- Backpressure: DONE is held indefinitely until `out_ready` is asserted.

## Configuration
- `DES_KEY_PARITY_EN` defined:
  - On accept, every key byte is checked for odd parity.
  - On any failure, the engine skips RUN and goes to DONE on the next edge with `out_data` = 0 and `out_err` = 1. `out_valid` therefore follows 1 cycle after accept.
  - With correct parity, `out_err` = 0 and timing is unchanged.
- `DES_KEY_PARITY_EN` undefined:
  - Parity bits are ignored, as PC1 discards them.
  - `out_err` is tied to 0.
  - No parity logic is generated.

## Test plan
1. Encrypt with R=1, key 133457799BBCDFF1, data 0123456789ABCDEF:
   - Result is 85E813540F0AB405 with `out_err`=0.
   - `out_valid` rises exactly 16 cycles after accept.
2. Decrypt with the same key and data 85E813540F0AB405:
   - Result is 0123456789ABCDEF.
   - Repeat tests 1 and 2 for R=2, 4, 8 and 16, checking latencies 8, 4, 2 and 1.
3. Encrypt with key 0E329232EA6D0D73, data 8787878787878787:
   - Result is 0000000000000000.
   - Hold `out_ready`=0 for 10 cycles: `out_valid` and `out_data` stay stable and `in_ready` stays 0.
4. Back-to-back requests with `in_valid` held at 1 and `out_ready` at 1:
   - Exactly one accept per N+2 cycles.
   - No accept occurs while `busy` is high.
5. Assert `rst` at round 7 of a running encrypt:
   - `in_ready`=1, `out_valid`=0 and `busy`=0 immediately.
   - A new request after reset produces the correct result with no stale state.
6. With `DES_KEY_PARITY_EN` defined, key 0000000000000000 (even parity):
   - `out_valid` arrives 1 cycle after accept, with `out_err`=1 and `out_data`=0.
   - Without the macro, the same request completes normally with `out_err`=0.

Source files
------------

// File: rtl/des_block_engine.sv
// des_block_engine
// Iterative DES block cipher (encrypt and decrypt). One 64-bit block at a time
// with a valid/ready request port and a valid/ready response port.
// ROUNDS_PER_CYCLE Feistel rounds (1, 2, 4, 8 or 16) are evaluated combinationally
// each RUN cycle, so a block takes 16/ROUNDS_PER_CYCLE RUN cycles.
//
// Optional build macro: DES_KEY_PARITY_EN
//   defined   - each key byte is checked for odd parity on accept. A bad key skips
//               RUN and answers one cycle later with out_data=0 and out_err=1.
//   undefined - parity bits are ignored and out_err is tied to 0.
//
// Ports
//   clk, rst                  rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready       request handshake (in_ready = engine idle)
//   in_decrypt                0 = encrypt, 1 = decrypt
//   in_data, in_key           64-bit block and key, DES bit 1 is [63]
//   out_valid / out_ready     response handshake (out_valid = result held)
//   out_data, out_err         result block and key-parity error flag
//   busy                      engine is not idle
module des_block_engine #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_decrypt,
  input  logic [63:0] in_data,
  input  logic [63:0] in_key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        out_err,
  output logic        busy
);

  if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 4 &&
      ROUNDS_PER_CYCLE != 8 && ROUNDS_PER_CYCLE != 16) begin : g_bad_rounds
    $error("des_block_engine: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [4:0] STEP = 5'(ROUNDS_PER_CYCLE);

  // DES tables, 1-based bit numbers with bit 1 = MSB of the source vector.
  localparam int unsigned IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int unsigned FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
  localparam int unsigned PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int unsigned PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int unsigned E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
  localparam int unsigned P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  // S-boxes: entry (row*16 + col) is the nibble at [255 - 4*entry -: 4].
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  function automatic logic [63:0] perm_ip(input logic [63:0] x);
    logic [63:0] y;
    y = 64'd0;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [63:0] perm_fp(input logic [63:0] x);
    logic [63:0] y;
    y = 64'd0;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [55:0] perm_pc1(input logic [63:0] x);
    logic [55:0] y;
    y = 56'd0;
    for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [47:0] perm_pc2(input logic [55:0] x);
    logic [47:0] y;
    y = 48'd0;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [47:0] e_expand(input logic [31:0] x);
    logic [47:0] y;
    y = 48'd0;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] x);
    logic [31:0] y;
    y = 32'd0;
    for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_T[5'(i)])];
    return y;
  endfunction

  // DES f-function: expand, key mix, S-box substitution, P permutation.
  function automatic logic [31:0] eff(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    logic [5:0]  six;
    logic [5:0]  idx;
    logic [7:0]  base;
    x = e_expand(r) ^ k;
    s = 32'd0;
    for (int b = 0; b < 8; b++) begin
      six  = x[6'(47 - 6 * b) -: 6];
      idx  = {six[5], six[0], six[4:1]};  // row from outer bits, column from inner
      base = 8'd255 - {idx, 2'b00};
      s[5'(31 - 4 * b) -: 4] = SBOX[3'(b)][base -: 4];
    end
    return p_perm(s);
  endfunction

  // Rotate a 28-bit key half by 0..2 places, left for encrypt, right for decrypt.
  function automatic logic [27:0] rot28(input logic [27:0] h, input logic [1:0] amt,
                                        input logic right);
    logic [27:0] y;
    case ({right, amt})
      3'b001:  y = {h[26:0], h[27]};
      3'b010:  y = {h[25:0], h[27:26]};
      3'b101:  y = {h[0], h[27:1]};
      3'b110:  y = {h[1:0], h[27:2]};
      default: y = h;
    endcase
    return y;
  endfunction

  // Per-round rotate amount. Decrypt round 0 uses the unrotated key (K16 = C0||D0).
  function automatic logic [1:0] shift_amt(input logic [3:0] rnd, input logic dec);
    logic [1:0] a;
    case (rnd)
      4'd0:              a = dec ? 2'd0 : 2'd1;
      4'd1, 4'd8, 4'd15: a = 2'd1;
      default:           a = 2'd2;
    endcase
    return a;
  endfunction

  state_t      state_r;
  state_t      state_nxt_s;
  logic [31:0] l_r, r_r;
  logic [27:0] c_r, d_r;
  logic        mode_r;
  logic [4:0]  cnt_r;
  logic [63:0] out_data_r;
  logic [31:0] l_v_s, r_v_s, tmp_s;
  logic [27:0] c_v_s, d_v_s;
  logic [3:0]  rnd_s;
  logic [1:0]  amt_s;
  logic [47:0] sub_s;
  logic [4:0]  cnt_nxt_s;
  logic        accept_s;
  logic        run_last_s;
  logic        key_bad_s;

  assign accept_s   = in_valid && (state_r == IDLE);
  assign cnt_nxt_s  = cnt_r + STEP;
  assign run_last_s = (state_r == RUN) && (cnt_nxt_s == 5'd16);

`ifdef DES_KEY_PARITY_EN
  // True when every key byte has an odd number of ones.
  function automatic logic key_parity_ok(input logic [63:0] k);
    logic ok;
    ok = 1'b1;
    for (int b = 0; b < 8; b++) ok = ok & (^k[6'(8 * b) +: 8]);
    return ok;
  endfunction

  logic out_err_r;

  assign key_bad_s = !key_parity_ok(in_key);
  assign out_err   = out_err_r;

  // Error flag is captured at accept and held until the next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_err_r <= 1'b0;
    end else if (accept_s) begin
      out_err_r <= key_bad_s;
    end
  end
`else
  assign key_bad_s = 1'b0;
  assign out_err   = 1'b0;
`endif

  // Chain of ROUNDS_PER_CYCLE Feistel rounds starting at round cnt_r.
  always_comb begin
    l_v_s = l_r;
    r_v_s = r_r;
    c_v_s = c_r;
    d_v_s = d_r;
    rnd_s = 4'd0;
    amt_s = 2'd0;
    sub_s = 48'd0;
    tmp_s = 32'd0;
    for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
      rnd_s = cnt_r[3:0] + 4'(j);
      amt_s = shift_amt(rnd_s, mode_r);
      c_v_s = rot28(c_v_s, amt_s, mode_r);
      d_v_s = rot28(d_v_s, amt_s, mode_r);
      sub_s = perm_pc2({c_v_s, d_v_s});
      tmp_s = r_v_s;
      r_v_s = l_v_s ^ eff(r_v_s, sub_s);
      l_v_s = tmp_s;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_nxt_s = key_bad_s ? DONE : RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (run_last_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Block/key state load on accept, round update in RUN, result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l_r        <= 32'd0;
      r_r        <= 32'd0;
      c_r        <= 28'd0;
      d_r        <= 28'd0;
      mode_r     <= 1'b0;
      cnt_r      <= 5'd0;
      out_data_r <= 64'd0;
    end else if (accept_s) begin
      {l_r, r_r} <= perm_ip(in_data);
      {c_r, d_r} <= perm_pc1(in_key);
      mode_r     <= in_decrypt;
      cnt_r      <= 5'd0;
      if (key_bad_s) begin
        out_data_r <= 64'd0;
      end
    end else if (state_r == RUN) begin
      l_r   <= l_v_s;
      r_r   <= r_v_s;
      c_r   <= c_v_s;
      d_r   <= d_v_s;
      cnt_r <= cnt_nxt_s;
      if (run_last_s) begin
        out_data_r <= perm_fp({r_v_s, l_v_s});  // halves swapped after round 16
      end
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign busy      = (state_r != IDLE);
  assign out_data  = out_data_r;

endmodule
